shift_xfer_ctrl: RTL



---
 rtl/shift_xfer_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/shift_xfer_ctrl.sv
// rtl/shift_xfer_ctrl.sv - serial transfer sequencer around an N-bit universal shift register
module shift_xfer_ctrl #(
  parameter int N   = 8,
  parameter int DIV = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         dir,
  input  logic [N-1:0] din,
  input  logic         abort,
  input  logic         sin,
  output logic         ready,
  output logic         busy,
  output logic         sout,
  output logic         shift_strobe,
  output logic [N-1:0] dout,
  output logic         done
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W = $clog2(N);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [N-1:0]     shreg;
  logic             dir_q;
  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic             strobe_int;

  // Strobe marks the last clock of a bit period; depends on registered state only.
  assign strobe_int = (state == ST_SHIFT) && (div_cnt == DIV_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode: accept, abort, final shift, single-cycle DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (strobe_int && (bit_cnt == BIT_LAST)) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Shift register, latched direction and counters; one register op per edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      shreg   <= '0;
      dir_q   <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            shreg   <= din;
            dir_q   <= dir;
            div_cnt <= '0;
            bit_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          // Abort leaves the register frozen with whatever was shifted so far.
          if (!abort) begin
            if (strobe_int) begin
              if (dir_q) begin
                shreg <= {sin, shreg[N-1:1]};
              end else begin
                shreg <= {shreg[N-2:0], sin};
              end
              div_cnt <= '0;
              if (bit_cnt != BIT_LAST) begin
                bit_cnt <= bit_cnt + BIT_W'(1);
              end
            end else begin
              div_cnt <= div_cnt + DIV_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Status and serial output decode from registered state.
  always_comb begin
    ready        = (state == ST_IDLE);
    busy         = (state == ST_SHIFT) || (state == ST_DONE);
    done         = (state == ST_DONE);
    shift_strobe = strobe_int;
    sout         = 1'b0;
    if (state == ST_SHIFT) begin
      sout = dir_q ? shreg[0] : shreg[N-1];
    end
    dout = shreg;
  end

endmodule
